// File: rtl/sp_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// sp_memory_arbiter_if
//
// Bundle of NUM_PORTS Wishbone B4 classic slave ports, flattened so port p
// occupies slice [p*W +: W] of each vector.
//
//   wb_cyc_i / wb_stb_i / wb_we_i   per-port cycle, strobe, write enable
//   wb_adr_i                        per-port 32-bit byte address
//   wb_dat_i / wb_sel_i             per-port write data and byte selects
//   wb_dat_o                        per-port read data (zero outside own ack)
//   wb_ack_o / wb_err_o             per-port one-cycle response pulses
//
// Handshake: a port requests while cyc && stb are high and holds adr, we,
// dat and sel stable until it sees ack or err; dropping cyc before the
// response withdraws the request and no response is ever issued for it.
//
// Modports: master = the requesters, slave = the arbiter.
// ---------------------------------------------------------------------------
interface sp_memory_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH     = 32
);
  logic [NUM_PORTS-1:0]           wb_cyc_i;
  logic [NUM_PORTS-1:0]           wb_stb_i;
  logic [NUM_PORTS-1:0]           wb_we_i;
  logic [NUM_PORTS*32-1:0]        wb_adr_i;
  logic [NUM_PORTS*WIDTH-1:0]     wb_dat_i;
  logic [NUM_PORTS*(WIDTH/8)-1:0] wb_sel_i;
  logic [NUM_PORTS*WIDTH-1:0]     wb_dat_o;
  logic [NUM_PORTS-1:0]           wb_ack_o;
  logic [NUM_PORTS-1:0]           wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/sp_memory_arbiter.sv
// ---------------------------------------------------------------------------
// sp_memory_arbiter
//
// Round-robin arbiter sharing one single-port memory core among NUM_PORTS
// Wishbone classic slave ports. One access at a time, three cycles each:
// IDLE (arbitrate) -> ACCESS (drive memory) -> RESP (ack/err to the owner).
// Addresses beyond the memory are answered with err and never reach memory.
//
// Ports:
//   clk_i, rst_ni     clock (rising edge), asynchronous active-low reset
//   wb                Wishbone port bundle (slave modport)
//   mem_cs_o          memory chip select (ACCESS only, in range, cyc held)
//   mem_we_o          memory write enable
//   mem_addr_o        memory word address
//   mem_be_o          memory byte enables
//   mem_wdata_o       memory write data
//   mem_rdata_i       memory read data, valid the cycle after a read cs
//   grant_o           one-hot current owner, zero in IDLE
//   state_o           current FSM state, for observation
// ---------------------------------------------------------------------------
module sp_memory_arbiter #(
  parameter  int NUM_PORTS = 2,
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 1024,
  localparam int ADDR_LSB  = $clog2(WIDTH/8),
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = WIDTH/8,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sp_memory_arbiter_if.slave   wb,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [BW-1:0]        mem_be_o,
  output logic [WIDTH-1:0]     mem_wdata_o,
  input  logic [WIDTH-1:0]     mem_rdata_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        owner_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic                 err_q;

  logic [NUM_PORTS-1:0] req;
  logic [PW-1:0]        win_idx;
  logic                 win_oob;
  logic                 cur_cyc;
  logic                 cur_we;
  logic [AW-1:0]        cur_word;
  logic [BW-1:0]        cur_sel;
  logic [WIDTH-1:0]     cur_dat;
  logic                 resp_live;

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  // First requesting port at or after rr_ptr_q, searching upward with wrap.
  always_comb begin : pick_winner
    int   cand;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_PORTS;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  // Any byte-address bit above the memory's span flags the access as an error.
  assign win_oob = |wb.wb_adr_i[int'(win_idx)*32 + AW + ADDR_LSB +: 32 - AW - ADDR_LSB];

  // Owner's bus fields; the byte offset below ADDR_LSB is deliberately dropped.
  assign cur_cyc  = wb.wb_cyc_i[owner_q];
  assign cur_we   = wb.wb_we_i[owner_q];
  assign cur_word = wb.wb_adr_i[int'(owner_q)*32 + ADDR_LSB +: AW];
  assign cur_sel  = wb.wb_sel_i[int'(owner_q)*BW +: BW];
  assign cur_dat  = wb.wb_dat_i[int'(owner_q)*WIDTH +: WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= NUM_PORTS'(1) << win_idx;
            owner_q <= win_idx;
            err_q   <= win_oob;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // An abort leaves rr_ptr_q alone so the aborting port keeps priority.
          if (!cur_cyc) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rr_ptr_q <= (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
          grant_q  <= '0;
          state_q  <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory side: every output is held at zero unless the chip is selected.
  always_comb begin
    mem_cs_o    = (state_q == ACCESS) && cur_cyc && !err_q;
    mem_we_o    = mem_cs_o && cur_we;
    mem_addr_o  = mem_cs_o ? cur_word : '0;
    mem_be_o    = mem_cs_o ? cur_sel  : '0;
    mem_wdata_o = mem_cs_o ? cur_dat  : '0;
  end

  // Response goes out only if the owner is still in its cycle.
  assign resp_live = (state_q == RESP) && cur_cyc;

  always_comb begin
    wb.wb_ack_o = '0;
    wb.wb_err_o = '0;
    wb.wb_dat_o = '0;
    if (resp_live) begin
      if (err_q) begin
        wb.wb_err_o = grant_q;
      end else begin
        wb.wb_ack_o = grant_q;
        if (!cur_we) begin
          wb.wb_dat_o[int'(owner_q)*WIDTH +: WIDTH] = mem_rdata_i;
        end
      end
    end
  end

  assign grant_o = grant_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_sp_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sp_memory_arbiter
//
// Directed steps (reset mid-access, write/read, contention, out-of-range,
// abort, byte enables) followed by a randomized multi-port phase checked
// against a word-array memory model and a round-robin selection rule.
// ---------------------------------------------------------------------------
module tb_sp_memory_arbiter;
  localparam int NP = 2;
  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int BW = W/8;
  localparam int AW = 10;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          mem_cs_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  logic [W-1:0]  mem_wdata_o;
  logic [W-1:0]  mem_rdata_i;
  logic [NP-1:0] grant_o;
  logic [1:0]    state_dbg;

  sp_memory_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

  sp_memory_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb          (bus),
    .mem_cs_o    (mem_cs_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .grant_o     (grant_o),
    .state_o     (state_dbg)
  );

  // Single-port memory core behind the arbiter
  logic [W-1:0] mem_arr [D];
  always @(posedge clk_i) begin
    if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) mem_arr[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata_i <= mem_arr[mem_addr_o];
      end
    end
  end

  // Reference memory contents, updated when a write is acknowledged
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [31:0] adr);
    return adr >= 32'(D*BW);
  endfunction

  task automatic apply_write(input logic [31:0] adr, input logic [W-1:0] dat, input logic [BW-1:0] sel);
    logic [W-1:0] wd;
    wd = ref_mem[adr/BW];
    for (int b = 0; b < BW; b++) if (sel[b]) wd[b*8 +: 8] = dat[b*8 +: 8];
    ref_mem[adr/BW] = wd;
  endtask

  function automatic int rr_pick(input logic [NP-1:0] reqs, input int ptr);
    for (int i = 0; i < NP; i++) if (reqs[(ptr + i) % NP]) return (ptr + i) % NP;
    return -1;
  endfunction

  // Driver tasks
  task automatic drive_edge(); @(posedge clk_i); #1; endtask
  task automatic sample_edge(); @(negedge clk_i); endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] adr,
                         input logic [W-1:0] dat, input logic [BW-1:0] sel);
    bus.wb_cyc_i[p] = 1'b1;
    bus.wb_stb_i[p] = 1'b1;
    bus.wb_we_i[p]  = we;
    bus.wb_adr_i[p*32 +: 32] = adr;
    bus.wb_dat_i[p*W +: W]   = dat;
    bus.wb_sel_i[p*BW +: BW] = sel;
  endtask

  task automatic clr_req(input int p);
    bus.wb_cyc_i[p] = 1'b0;
    bus.wb_stb_i[p] = 1'b0;
    bus.wb_we_i[p]  = 1'b0;
  endtask

  // One access on an otherwise quiet bus, checked cycle by cycle
  task automatic single(input string tag, input int p, input logic we, input logic [31:0] adr,
                        input logic [W-1:0] dat, input logic [BW-1:0] sel, input bit abort);
    bit go;
    logic [W-1:0] exp_d;
    go = !abort && !is_oob(adr);
    drive_edge(); set_req(p, we, adr, dat, sel);
    sample_edge();
    check($sformatf("%s_n_grant", tag), grant_o, '0);
    check($sformatf("%s_n_cs", tag), mem_cs_o, 1'b0);
    drive_edge(); if (abort) clr_req(p);
    sample_edge();
    check($sformatf("%s_n1_grant", tag), grant_o, NP'(1) << p);
    check($sformatf("%s_n1_cs", tag), mem_cs_o, go);
    check($sformatf("%s_n1_we", tag), mem_we_o, go ? we : 1'b0);
    check($sformatf("%s_n1_addr", tag), mem_addr_o, go ? adr/BW : 0);
    check($sformatf("%s_n1_be", tag), mem_be_o, go ? sel : '0);
    check($sformatf("%s_n1_wdata", tag), mem_wdata_o, go ? dat : '0);
    drive_edge(); sample_edge();
    exp_d = (go && !we) ? ref_mem[adr/BW] : '0;
    check($sformatf("%s_n2_cs", tag), mem_cs_o, 1'b0);
    check($sformatf("%s_n2_ack", tag), bus.wb_ack_o, go ? NP'(1) << p : '0);
    check($sformatf("%s_n2_err", tag), bus.wb_err_o, (!abort && is_oob(adr)) ? NP'(1) << p : '0);
    check($sformatf("%s_n2_dat", tag), bus.wb_dat_o[p*W +: W], exp_d);
    if (go && we) apply_write(adr, dat, sel);
    drive_edge(); clr_req(p);
    sample_edge();
    check($sformatf("%s_n3_resp", tag), bus.wb_ack_o | bus.wb_err_o, '0);
  endtask

  // Per-cycle protocol invariants
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("inv_ack_err", bus.wb_ack_o & bus.wb_err_o, '0);
      check("inv_one_resp", $countones(bus.wb_ack_o | bus.wb_err_o) <= 1, 1);
      check("inv_one_grant", $countones(grant_o) <= 1, 1);
      check("inv_resp_owner", (bus.wb_ack_o | bus.wb_err_o) & ~grant_o, '0);
      if (!mem_cs_o) check("inv_mem_quiet", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
      for (int p = 0; p < NP; p++)
        if (!bus.wb_ack_o[p]) check("inv_dat_quiet", bus.wb_dat_o[p*W +: W], '0);
    end
  end

  // Random-phase state
  bit            busy [NP];
  bit            resp_flag [NP];
  logic          rq_we [NP];
  logic [31:0]   rq_adr [NP];
  logic [W-1:0]  rq_dat [NP];
  logic [BW-1:0] rq_sel [NP];
  int            rq_start [NP];
  logic [NP-1:0] req_d1, req_d2, req_now;
  int            model_ptr, exp_w, n_resp, last_k, resp_p;

  initial begin
    rst_ni = 1'b0;
    bus.wb_cyc_i = '0; bus.wb_stb_i = '0; bus.wb_we_i = '0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    mem_rdata_i = '0;
    for (int i = 0; i < D; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end

    // Reset values
    repeat (3) drive_edge();
    sample_edge();
    check("rst_grant", grant_o, '0);
    check("rst_cs", mem_cs_o, 1'b0);
    check("rst_resp", bus.wb_ack_o | bus.wb_err_o, '0);
    drive_edge(); rst_ni = 1'b1; mon_en = 1'b1;

    // Reset asserted in the middle of ACCESS discards the write
    drive_edge(); set_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    sample_edge();
    drive_edge(); sample_edge();
    check("rst_pre_cs", mem_cs_o, 1'b1);
    #1 rst_ni = 1'b0; #1;
    check("rst_mid_cs", mem_cs_o, 1'b0);
    check("rst_mid_grant", grant_o, '0);
    check("rst_mid_mem", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, '0);
    check("rst_mid_resp", bus.wb_ack_o | bus.wb_err_o, '0);
    check("rst_mid_dat", bus.wb_dat_o, '0);
    drive_edge(); clr_req(0);
    drive_edge(); sample_edge();
    check("rst_hold_resp", bus.wb_ack_o | bus.wb_err_o, '0);
    drive_edge(); rst_ni = 1'b1;

    // Contention: both ports request continuously, expect 0,1,0,1 every 3 cycles
    drive_edge();
    set_req(0, 1'b0, 32'h20, '0, 4'hF);
    set_req(1, 1'b0, 32'h40, '0, 4'hF);
    exp_q = '{0, 1, 0, 1};
    last_k = -1;
    for (int k = 0; k < 12; k++) begin
      sample_edge();
      if (k == 1) check("cont_first_grant", grant_o, 2'b01);
      if ((bus.wb_ack_o | bus.wb_err_o) != '0) begin
        resp_p = (bus.wb_ack_o[1] | bus.wb_err_o[1]) ? 1 : 0;
        check("cont_err", bus.wb_err_o, '0);
        if (exp_q.size() > 0) check("cont_order", resp_p, exp_q.pop_front());
        else check("cont_extra", resp_p, 32'hFFFF_FFFF);
        if (last_k < 0) check("cont_first_lat", k, 2);
        else check("cont_gap", k - last_k, 3);
        check("cont_dat", bus.wb_dat_o[resp_p*W +: W], ref_mem[(resp_p == 0 ? 32'h20 : 32'h40)/BW]);
        last_k = k;
      end
      drive_edge();
    end
    clr_req(0); clr_req(1);
    check("cont_count", exp_q.size(), 0);

    // Single write then read, out of range, abort, byte enables
    single("wr", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    single("rd", 0, 1'b0, 32'h10, '0, 4'hF, 1'b0);
    single("oob", 1, 1'b0, 32'h1000, '0, 4'hF, 1'b0);
    single("abort", 0, 1'b0, 32'h10, '0, 4'hF, 1'b1);

    // After the abort port 0 still has priority over port 1
    drive_edge();
    set_req(0, 1'b0, 32'h10, '0, 4'hF);
    set_req(1, 1'b0, 32'h44, '0, 4'hF);
    sample_edge();
    drive_edge(); sample_edge();
    check("abort_favour", grant_o, 2'b01);
    drive_edge(); sample_edge();
    check("abort_favour_ack", bus.wb_ack_o, 2'b01);
    check("abort_favour_dat", bus.wb_dat_o[0 +: W], ref_mem[32'h10/BW]);
    drive_edge(); clr_req(0); clr_req(1);
    sample_edge();

    single("be", 1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
    single("be_rd", 0, 1'b0, 32'h10, '0, 4'hF, 1'b0);

    // Randomized phase from a fresh reset
    drive_edge(); rst_ni = 1'b0;
    drive_edge(); rst_ni = 1'b1;
    req_d1 = '0; req_d2 = '0; model_ptr = 0; n_resp = 0;
    for (int p = 0; p < NP; p++) begin busy[p] = 1'b0; resp_flag[p] = 1'b0; end
    for (int c = 0; c < 460; c++) begin
      drive_edge();
      for (int p = 0; p < NP; p++) begin
        if (resp_flag[p]) begin
          clr_req(p); busy[p] = 1'b0; resp_flag[p] = 1'b0;
        end else if (!busy[p] && c < 400 && $urandom_range(0, 2) == 0) begin
          rq_we[p] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) rq_adr[p] = 32'($urandom_range(D*BW, 32'h0000_FFFF));
          else rq_adr[p] = 32'($urandom_range(0, 15) * BW + $urandom_range(0, BW-1));
          rq_dat[p] = $urandom;
          rq_sel[p] = BW'($urandom_range(1, (1 << BW) - 1));
          set_req(p, rq_we[p], rq_adr[p], rq_dat[p], rq_sel[p]);
          busy[p] = 1'b1; rq_start[p] = c;
        end
      end
      sample_edge();
      req_now = bus.wb_cyc_i & bus.wb_stb_i;
      for (int p = 0; p < NP; p++) begin
        if (bus.wb_ack_o[p] | bus.wb_err_o[p]) begin
          n_resp++;
          check("rand_busy", busy[p], 1'b1);
          exp_w = rr_pick(req_d2, model_ptr);
          check("rand_winner", p, exp_w);
          model_ptr = (exp_w + 1) % NP;
          check("rand_ack", bus.wb_ack_o[p], !is_oob(rq_adr[p]));
          check("rand_err", bus.wb_err_o[p], is_oob(rq_adr[p]));
          check("rand_dat", bus.wb_dat_o[p*W +: W],
                (!is_oob(rq_adr[p]) && !rq_we[p]) ? ref_mem[rq_adr[p]/BW] : '0);
          check("rand_latency", (c - rq_start[p]) <= 3*NP + 2, 1);
          if (!is_oob(rq_adr[p]) && rq_we[p]) apply_write(rq_adr[p], rq_dat[p], rq_sel[p]);
          resp_flag[p] = 1'b1;
        end
      end
      req_d2 = req_d1;
      req_d1 = req_now;
    end
    for (int p = 0; p < NP; p++) check("drain_idle", busy[p], 1'b0);
    check("rand_resp_count", n_resp > 50, 1);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_memory_arbiter.md
# sp_memory_arbiter

Round-robin arbiter that shares one single-port memory core among `NUM_PORTS` Wishbone B4 classic slave ports. It sits between the system interconnect masters and the `sp_memory` core interface (chip select, write enable, word address, byte enables, write data, read data). It serialises accesses, one at a time, with a fixed 3-cycle handshake. Out-of-range addresses are answered with a bus error.

## Interface
- `NUM_PORTS`, 2: number of Wishbone requesters (2..8).
- `WIDTH`, 32: data width in bits (multiple of 8).
- `DEPTH`, 1024: memory depth in words.
- Derived, not overridable:
  - `ADDR_LSB` = $clog2(WIDTH/8).
  - `AW` = $clog2(DEPTH).
- Per-port buses below are flattened; port p occupies slice [p*W +: W].

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `wb_cyc_i`  in  NUM_PORTS  per-port cycle valid.
- `wb_stb_i`  in  NUM_PORTS  per-port strobe.
- `wb_we_i`  in  NUM_PORTS  per-port write enable.
- `wb_adr_i`  in  NUM_PORTS*32  per-port byte address.
- `wb_dat_i`  in  NUM_PORTS*WIDTH  per-port write data.
- `wb_sel_i`  in  NUM_PORTS*(WIDTH/8)  per-port byte selects.
- `wb_dat_o`  out  NUM_PORTS*WIDTH  per-port read data; zero except in that port's ack cycle.
- `wb_ack_o`  out  NUM_PORTS  per-port acknowledge, 1-cycle pulse.
- `wb_err_o`  out  NUM_PORTS  per-port error, 1-cycle pulse.
- `mem_cs_o`  out  1  memory chip select.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  AW  memory word address.
- `mem_be_o`  out  WIDTH/8  memory byte enables.
- `mem_wdata_o`  out  WIDTH  memory write data.
- `mem_rdata_i`  in  WIDTH  memory read data, valid 1 cycle after a read cs.
- `grant_o`  out  NUM_PORTS  one-hot current owner; zero in IDLE.

## Operation
- Request on port p: `wb_cyc_i[p] && wb_stb_i[p]`.
- Ports hold `adr/we/dat/sel` stable until ack or err.
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - If any request: select winner, register one-hot grant, register error flag, go to ACCESS.
  - Winner is the first requesting port at or after `rr_ptr`, searching upward with wrap.
  - Error flag = any address bit above `AW+ADDR_LSB-1` set.
- ACCESS
  - `mem_cs_o` = 1 only if the winner's cyc is still high and the error flag is clear.
  - Memory outputs are driven combinationally from the granted port:
    - `mem_addr_o` = adr[AW+ADDR_LSB-1:ADDR_LSB]; low `ADDR_LSB` bits ignored.
    - `mem_we_o` = we, `mem_be_o` = sel, `mem_wdata_o` = dat.
  - If the winner's cyc is low (abort): go to IDLE, no response, `rr_ptr` unchanged.
  - Otherwise go to RESP.
- RESP
  - If the winner's cyc is still high:
    - Pulse `wb_ack_o[w]`, or `wb_err_o[w]` if the error flag is set.
    - For a read ack, `wb_dat_o[w]` = `mem_rdata_i`. For writes and err, `wb_dat_o[w]` = 0.
  - If the winner's cyc is low: no pulse.
  - Always: `rr_ptr` ← (w+1) mod NUM_PORTS, clear grant, go to IDLE.
- Ack and err are never both set. At most one port is responded to per cycle.
- Memory outputs are zero whenever `mem_cs_o` = 0.
- Non-granted ports see ack, err and dat_o all zero.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE, `rr_ptr` = 0, grant = 0.
  - All outputs = 0.
- Reset asserted mid-transaction discards the access. No ack or err is ever issued for it.
- Latency: request sampled in IDLE at cycle N → `mem_cs_o` at N+1 → ack/err at N+2.
- Throughput: one access per 3 cycles. No back-to-back overlap.
- A new request on the same port is sampled in IDLE at N+3 at the earliest.
- Requests arriving while the FSM is busy wait; they are not lost because the requester holds stb.
- Starvation bound: a waiting port is granted within NUM_PORTS arbitration rounds, i.e. 3*NUM_PORTS cycles.
- Simultaneous requests:
  - The lowest index at or after `rr_ptr` wins.
  - The pointer wraps from NUM_PORTS-1 to 0.

## Test plan
- Reset values:
  - Stimulus: assert `rst_ni` = 0 mid-ACCESS.
  - Expect: all outputs 0 in the same cycle. After release, the first grant goes to port 0 when both ports request.
- Single write then read:
  - Stimulus: port 0 writes 0xDEADBEEF to byte address 0x10 with sel = 4'hF, then reads address 0x10.
  - Expect: during the write, `mem_cs_o` = 1, `mem_we_o` = 1 and `mem_addr_o` = 4 at N+1; ack at N+2. The read ack carries 0xDEADBEEF.
- Contention:
  - Stimulus: ports 0 and 1 both request continuously from reset.
  - Expect: grants alternate 0,1,0,1; acks are 3 cycles apart; no port is acked twice in a row.
- Out of range:
  - Stimulus: port 1 reads byte address 0x1000 (DEPTH = 1024, WIDTH = 32).
  - Expect: `mem_cs_o` stays 0 throughout; `wb_err_o[1]` pulses at N+2; `wb_ack_o` stays 0.
- Abort:
  - Stimulus: port 0 drops cyc during ACCESS.
  - Expect: `mem_cs_o` = 0 in that cycle; no ack or err; the next grant still favours port 0 (`rr_ptr` unchanged).
- Byte enables:
  - Stimulus: write with sel = 4'b0101.
  - Expect: `mem_be_o` = 4'b0101 in the ACCESS cycle only, and 0 otherwise.
